// File: rtl/mem_seq_ctrl.sv
// rtl/mem_seq_ctrl.sv - operand load/replay sequencer for the dual-bank Booth multiplier memory
module mem_seq_ctrl #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_N,
  input  logic                  Load_Valid,
  input  logic [DATA_WIDTH-1:0] Load_A,
  input  logic [DATA_WIDTH-1:0] Load_B,
  output logic                  Load_Ready,
  input  logic                  Clr,
  input  logic                  Start,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [DATA_WIDTH-1:0] Mem_Data_In,
  output logic                  Mem_W_En,
  output logic                  Mem_M_Sel,
  input  logic [DATA_WIDTH-1:0] Mem_A_In,
  input  logic [DATA_WIDTH-1:0] Mem_B_In,
  output logic [DATA_WIDTH-1:0] Mul_A,
  output logic [DATA_WIDTH-1:0] Mul_B,
  output logic                  Mul_Start,
  input  logic                  Mul_Done,
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_WIDTH:0]   Count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR1,
    S_WR2,
    S_RD,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_e;

  localparam logic [ADDR_WIDTH:0] PTR_ZERO = '0;
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]     rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [DATA_WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [DATA_WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [ADDR_WIDTH:0]     rptr_inc;
  logic                    not_full;

  // wptr's top bit set means every address holds a pair; no further loads
  assign not_full = ~wptr_q[ADDR_WIDTH];
  assign rptr_inc = rptr_q + PTR_ONE;

  // state and datapath registers; every output flag derives from state so reset clears them at once
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  // next-state and register updates; IDLE arbitrates Start over Clr over load
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    a_d     = a_q;
    b_d     = b_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          rptr_d  = '0;
          state_d = (wptr_q == PTR_ZERO) ? S_FIN : S_RD;
        end else if (Clr) begin
          wptr_d = '0;
        end else if (Load_Valid && not_full) begin
          a_d     = Load_A;
          b_d     = Load_B;
          state_d = S_WR1;
        end
      end
      S_WR1: state_d = S_WR2;
      S_WR2: begin
        wptr_d  = wptr_q + PTR_ONE;
        state_d = S_IDLE;
      end
      S_RD: begin
        mul_a_d = Mem_A_In;
        mul_b_d = Mem_B_In;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (Mul_Done) begin
          rptr_d  = rptr_inc;
          state_d = (rptr_inc == wptr_q) ? S_FIN : S_RD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // memory port decode: writes in WR1/WR2, read address in RD, quiet elsewhere
  always_comb begin
    Mem_Addr    = '0;
    Mem_Data_In = '0;
    Mem_W_En    = 1'b0;
    Mem_M_Sel   = 1'b0;
    case (state_q)
      S_WR1: begin
        Mem_Addr    = wptr_q[ADDR_WIDTH-1:0];
        Mem_Data_In = a_q;
        Mem_W_En    = 1'b1;
      end
      S_WR2: begin
        Mem_Addr    = wptr_q[ADDR_WIDTH-1:0];
        Mem_Data_In = b_q;
        Mem_W_En    = 1'b1;
        Mem_M_Sel   = 1'b1;
      end
      S_RD: begin
        Mem_Addr = rptr_q[ADDR_WIDTH-1:0];
      end
      default: begin
        Mem_Addr = '0;
      end
    endcase
  end

  assign Load_Ready = (state_q == S_IDLE) && not_full;
  assign Mul_Start  = (state_q == S_ISSUE);
  assign Done       = (state_q == S_FIN);
  assign Busy       = (state_q != S_IDLE);
  assign Count      = wptr_q;
  assign Mul_A      = mul_a_q;
  assign Mul_B      = mul_b_q;

endmodule

// File: doc/mem_seq_ctrl.md
# mem_seq_ctrl

Sequencing controller for the dual-bank operand memory of the radix-8 Booth multiplier. It accepts operand pairs over a valid/ready load port and writes the multiplicand into bank 1 and the multiplier into bank 2 at the same address. On a run request it replays every stored pair, in address order, into the Booth multiplier. It handshakes with the multiplier's done signal between pairs and signals completion of the batch.

## Interface
- DATA_WIDTH, 9: operand width; matches the memory data width.
- ADDR_WIDTH, 4: memory address width; capacity is 2**ADDR_WIDTH pairs.

- Clk  in  1  system clock, rising edge.
- Rst_N  in  1  asynchronous, active-low reset.
- Load_Valid  in  1  operand pair present on Load_A/Load_B.
- Load_A  in  DATA_WIDTH  multiplicand, written to bank 1.
- Load_B  in  DATA_WIDTH  multiplier, written to bank 2.
- Load_Ready  out  1  controller can accept a pair.
- Clr  in  1  empties the stored batch. Honoured only in IDLE.
- Start  in  1  run request. Honoured only in IDLE.
- Mem_Addr  out  ADDR_WIDTH  to memory Addr.
- Mem_Data_In  out  DATA_WIDTH  to memory Data_In.
- Mem_W_En  out  1  to memory W_En.
- Mem_M_Sel  out  1  to memory M_Sel (0 = bank 1, 1 = bank 2).
- Mem_A_In  in  DATA_WIDTH  from memory Data1_O (bank 1, combinational read).
- Mem_B_In  in  DATA_WIDTH  from memory Data2_O (bank 2, combinational read).
- Mul_A, Mul_B  out  DATA_WIDTH  registered operands to the multiplier.
- Mul_Start  out  1  one-cycle start pulse to the multiplier.
- Mul_Done  in  1  multiplier finished the current pair.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when the batch has finished.
- Count  out  ADDR_WIDTH+1  number of stored pairs.

## Operation
- States: IDLE, WR1, WR2, RD, ISSUE, WAIT, FIN. Registers: wptr (ADDR_WIDTH+1 bits, equals Count), rptr (ADDR_WIDTH+1 bits), A/B capture registers, Mul_A, Mul_B.
- Reset values: state IDLE; Count, rptr, Mul_A, Mul_B, Done and Mul_Start all 0; Load_Ready 1; Busy 0. Memory contents are not cleared; Count=0 makes them unreachable.
- Load_Ready is high only when the state is IDLE and Count < 2**ADDR_WIDTH.
- IDLE priority, highest first: Start, then Clr, then load.
  - If Start is high, go to RD with rptr=0, or to FIN if Count=0.
  - Else if Clr is high, set Count to 0.
  - Else if Load_Valid and Load_Ready are both high, capture Load_A and Load_B and go to WR1.
- WR1: Mem_W_En=1, Mem_M_Sel=0, Mem_Addr=wptr[ADDR_WIDTH-1:0], Mem_Data_In=captured A. Go to WR2.
- WR2: same as WR1 but Mem_M_Sel=1 and Mem_Data_In=captured B. Increment Count. Go to IDLE.
- RD: Mem_W_En=0, Mem_Addr=rptr[ADDR_WIDTH-1:0]. At the clock edge, register Mem_A_In into Mul_A and Mem_B_In into Mul_B. Go to ISSUE.
- ISSUE: Mul_Start=1. Go to WAIT.
- WAIT: Mul_A and Mul_B hold. On Mul_Done, increment rptr. If rptr+1 == Count, go to FIN; otherwise go to RD.
- FIN: Done=1 for one cycle. Go to IDLE. Count is kept, so the same batch can be re-run.
- Mem_* outputs decode combinationally from state and pointers. Outside WR1/WR2: Mem_W_En=0, Mem_M_Sel=0, Mem_Data_In=0. Outside WR1/WR2/RD: Mem_Addr=0.
- Mul_Done is ignored in every state except WAIT, including in the ISSUE cycle itself.
- Load_Valid, Clr and Start are ignored outside IDLE; no request is queued.

## Timing
- Load acceptance at edge t:
  - bank 1 write at edge t+1;
  - bank 2 write at edge t+2, where Count updates;
  - Load_Ready high again in cycle t+2 after the edge.
  - Sustained load throughput is 1 pair per 3 cycles.
- Run with Start sampled at edge t:
  - RD during cycle t..t+1;
  - Mul_A/Mul_B valid and Mul_Start high during cycle t+1..t+2;
  - WAIT from edge t+2.
- Per-pair overhead: 2 cycles plus the multiplier latency. Mul_Done seen at edge d gives the next RD in cycle d..d+1.
- Start with Count=0: Done is high in the cycle after Start is sampled.
- Full case (Count = 2**ADDR_WIDTH): wptr low bits wrap to 0, but Load_Ready stays 0, so no overwrite occurs. Count reaches 16 for ADDR_WIDTH=4.
- Rst_N low at any time, mid-write or mid-WAIT included: immediate return to reset values. Mul_Start and Mem_W_En drop asynchronously.

## Test plan
- Reset: hold Rst_N=0 with random inputs → Load_Ready=1, Busy=0, Done=0, Mul_Start=0, Mem_W_En=0, Count=0.
- Load 3 pairs (5,3), (-7,2), (255,1) back-to-back → writes occur at addresses 0, 1, 2, bank 1 then bank 2 each; Count=3; Load_Ready is low for 2 cycles after each accept.
- Start after that load, with a model multiplier asserting Mul_Done 4 cycles after each Mul_Start → 3 Mul_Start pulses carrying Mul_A/Mul_B = (5,3), (-7,2), (255,1) in order; one Done pulse after the third Mul_Done; Busy high throughout the run.
- Fill 16 pairs → Count=16 and Load_Ready=0; a further Load_Valid is not accepted; Clr → Count=0 and Load_Ready=1.
- Start with Count=0 → Done high in the next cycle, with no Mul_Start and no memory access; Start and Load_Valid together in IDLE → run begins and the load is not accepted.
- Assert Rst_N=0 during WAIT of pair 2 → outputs return to reset values immediately; after release, Count=0 and a subsequent Start gives an immediate Done.
